// File: rtl/dadda_wb_ctrl.sv
// dadda_wb_ctrl: Wishbone slave front-end for an 8x8 Dadda multiplier.
// Software loads operands (OPND) and writes CTRL.start. The block then holds
// mul_enable for the settle latency, captures mul_out into RESULT, and sets
// STATUS.done, which raises irq when CTRL.irq_en is set.
// Ports:
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   wbs_stb_i/cyc_i/we_i      Wishbone control
//   wbs_sel_i, wbs_adr_i      byte enables, byte address
//   wbs_dat_i / wbs_dat_o     write data / read data (non-zero only with ack)
//   wbs_ack_o                 one-cycle acknowledge
//   mul_a, mul_b, mul_enable  multiplier drive
//   mul_out                   multiplier product
//   irq                       level interrupt (done & irq_en)
module dadda_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          MUL_LATENCY = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_enable,
  input  logic [15:0] mul_out,
  output logic        irq
);

  localparam logic [3:0] LP_LOAD = 4'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPT} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_ack;
  logic        r_we;
  logic [1:0]  r_off;
  logic [1:0]  r_sel;
  logic [15:0] r_wdat;
  logic [31:0] r_rdata;
  logic [3:0]  r_cnt;
  logic        r_en;
  logic [7:0]  r_a, r_b;
  logic        r_irq_en, r_done, r_ovr;
  logic [15:0] r_result;

  logic        w_hit, w_busy, w_wr;
  logic        w_wr_opnd, w_wr_ctrl, w_wr_stat;
  logic        w_start_req, w_load, w_capt;
  logic [31:0] w_rdata;

  // Bits of the bus that no register uses.
  logic w_unused;
  assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // !r_ack keeps a held strobe from re-hitting during its own ack cycle.
  assign w_hit  = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~r_ack;
  assign w_busy = (r_state != S_IDLE);

  // Writes are latched at the hit and committed at the end of the ack cycle.
  assign w_wr        = r_ack & r_we;
  assign w_wr_opnd   = w_wr & (r_off == 2'd0);
  assign w_wr_ctrl   = w_wr & (r_off == 2'd1);
  assign w_wr_stat   = w_wr & (r_off == 2'd2);
  assign w_start_req = w_wr_ctrl & r_sel[0] & r_wdat[0];

  always_comb begin
    w_rdata = 32'h0;
    case (wbs_adr_i[3:2])
      2'd0:    w_rdata = {16'h0, r_b, r_a};
      2'd1:    w_rdata = {30'h0, r_irq_en, 1'b0};
      2'd2:    w_rdata = {29'h0, r_ovr, r_done, w_busy};
      default: w_rdata = {16'h0, r_result};
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_we    <= 1'b0;
      r_off   <= 2'd0;
      r_sel   <= 2'd0;
      r_wdat  <= 16'h0;
      r_rdata <= 32'h0;
    end else begin
      r_ack   <= w_hit;
      r_rdata <= (w_hit & ~wbs_we_i) ? w_rdata : 32'h0;
      if (w_hit) begin
        r_we   <= wbs_we_i;
        r_off  <= wbs_adr_i[3:2];
        r_sel  <= wbs_sel_i[1:0];
        r_wdat <= wbs_dat_i[15:0];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capt      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_req) begin
        w_state_nxt = S_RUN;
        w_load      = 1'b1;
      end
      S_RUN:  if (r_cnt == 4'd0) w_state_nxt = S_CAPT;
      S_CAPT: begin
        w_capt      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt    <= 4'd0;
      r_en     <= 1'b0;
      r_a      <= 8'h0;
      r_b      <= 8'h0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_result <= 16'h0;
    end else begin
      if (w_load)                                 r_cnt <= LP_LOAD;
      else if (r_state == S_RUN && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;

      if (w_load)      r_en <= 1'b1;
      else if (w_capt) r_en <= 1'b0;

      // Operands are frozen while an operation is in flight.
      if (w_wr_opnd & ~w_busy) begin
        if (r_sel[0]) r_a <= r_wdat[7:0];
        if (r_sel[1]) r_b <= r_wdat[15:8];
      end

      if (w_wr_ctrl & r_sel[0]) r_irq_en <= r_wdat[1];

      if (w_capt) r_result <= mul_out;

      // Capture is tested before the W1C so a same-cycle clear loses.
      if (w_load)                                  r_done <= 1'b0;
      else if (w_capt)                             r_done <= 1'b1;
      else if (w_wr_stat & r_sel[0] & r_wdat[1])   r_done <= 1'b0;

      if (w_busy & (w_start_req | w_wr_opnd))      r_ovr <= 1'b1;
      else if (w_wr_stat & r_sel[0] & r_wdat[2])   r_ovr <= 1'b0;
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_rdata;
  assign mul_a      = r_a;
  assign mul_b      = r_b;
  assign mul_enable = r_en;
  assign irq        = r_done & r_irq_en;

endmodule

// File: tb/tb_dadda_wb_ctrl.sv
// Bench for dadda_wb_ctrl: a cycle-level reference model (operation tracked as
// a remaining-enable-cycles count, product by plain arithmetic) checked against
// every output on every falling edge, plus directed literal checks.
module tb_dadda_wb_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          L    = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [7:0]  mul_a, mul_b;
  logic        mul_enable, irq;
  logic [15:0] mul_out;

  assign mul_out = 16'(mul_a) * 16'(mul_b);

  dadda_wb_ctrl #(.BASE_ADDR(BASE), .MUL_LATENCY(L)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .mul_a(mul_a), .mul_b(mul_b), .mul_enable(mul_enable),
    .mul_out(mul_out), .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- reference model ----------------
  logic [7:0]  m_a, m_b;
  logic        m_irqen, m_done, m_ovr, m_ack;
  logic [15:0] m_res;
  logic [31:0] m_rd;
  int          m_left;          // enable cycles still to come; 0 = idle
  logic        p_we;
  logic [1:0]  p_off;
  logic [31:0] p_dat;
  logic [3:0]  p_sel;

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_a = 0; m_b = 0; m_irqen = 0; m_done = 0; m_ovr = 0; m_ack = 0;
      m_res = 0; m_rd = 0; m_left = 0; p_we = 0; p_off = 0; p_dat = 0; p_sel = 0;
    end else begin
      logic        hit, busy, start;
      logic [31:0] rv;
      busy  = (m_left > 0);
      start = 0;
      hit   = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE[31:4]) && !m_ack;
      case (wbs_adr_i[3:2])
        2'd0:    rv = {16'h0, m_b, m_a};
        2'd1:    rv = {30'h0, m_irqen, 1'b0};
        2'd2:    rv = {29'h0, m_ovr, m_done, busy};
        default: rv = {16'h0, m_res};
      endcase
      if (m_ack && p_we) begin
        case (p_off)
          2'd0: if (busy) m_ovr = 1;
                else begin
                  if (p_sel[0]) m_a = p_dat[7:0];
                  if (p_sel[1]) m_b = p_dat[15:8];
                end
          2'd1: if (p_sel[0]) begin
                  m_irqen = p_dat[1];
                  if (p_dat[0]) begin
                    if (busy) m_ovr = 1; else start = 1;
                  end
                end
          2'd2: if (p_sel[0]) begin
                  if (p_dat[1]) m_done = 0;
                  if (p_dat[2]) m_ovr = 0;
                end
          default: ;
        endcase
      end
      if (busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_res  = 16'(m_a) * 16'(m_b);
          m_done = 1;
        end
      end
      if (start) begin
        m_left = L + 1;
        m_done = 0;
      end
      m_rd = (hit && !wbs_we_i) ? rv : 32'h0;
      if (hit) begin
        p_we = wbs_we_i; p_off = wbs_adr_i[3:2]; p_dat = wbs_dat_i; p_sel = wbs_sel_i;
      end
      m_ack = hit;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int en_cyc  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output logic acked);
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    acked = 0; rd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        acked = 1; rd = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0; wbs_sel_i = 0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    logic        a;
    wb_xfer(BASE + 32'(off), 1'b1, dat, sel, d, a);
    chk("wr_ack", 32'(a), 32'd1);
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] d);
    logic a;
    wb_xfer(BASE + 32'(off), 1'b0, 32'h0, 4'hf, d, a);
    chk("rd_ack", 32'(a), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        a;
    int          e0;

    repeat (2) @(negedge wb_clk_i);
    chk("reset_outs", {31'h0, wbs_ack_o, wbs_dat_o, mul_a, mul_b, mul_enable, irq}, 32'h0);
    wb_rst_i = 0;

    fork
      forever begin
        @(negedge wb_clk_i);
        if (mul_enable) en_cyc++;
        n_tests++;
        if ({wbs_ack_o, wbs_dat_o, mul_a, mul_b, mul_enable, irq} !==
            {m_ack, m_rd, m_a, m_b, m_left > 0, m_done & m_irqen}) begin
          n_fail++;
          $display("FAIL model_cmp t=%0t got ack=%b dat=%h a=%h b=%h en=%b irq=%b expected ack=%b dat=%h a=%h b=%h en=%b irq=%b",
                   $time, wbs_ack_o, wbs_dat_o, mul_a, mul_b, mul_enable, irq,
                   m_ack, m_rd, m_a, m_b, m_left > 0, m_done & m_irqen);
        end
      end
    join_none

    // 1: basic multiply, latency and enable width
    wr(4'h0, 32'h0000_0C03, 4'b0011);
    e0 = en_cyc;
    wr(4'h4, 32'h1, 4'b0001);
    repeat (L + 1) @(negedge wb_clk_i);
    rd(4'h8, d); chk("t1_status_busy", d, 32'h1);
    rd(4'h8, d); chk("t1_status_done", d, 32'h2);
    chk("t1_en_cycles", 32'(en_cyc - e0), 32'(L + 1));
    rd(4'hC, d); chk("t1_result", d, 32'h0024);
    rd(4'h8, d); chk("t1_done_kept", d, 32'h2);

    // 2: max operands, irq, W1C
    wr(4'h0, 32'h0000_FFFF, 4'b0011);
    wr(4'h4, 32'h3, 4'b0001);
    repeat (6) @(negedge wb_clk_i);
    rd(4'hC, d); chk("t2_result", d, 32'hFE01);
    chk("t2_irq_set", 32'(irq), 32'd1);
    wr(4'h8, 32'h2, 4'b0001);
    @(negedge wb_clk_i);
    chk("t2_irq_clr", 32'(irq), 32'd0);
    rd(4'h8, d); chk("t2_status", d, 32'h0);

    // 6: W1C of done lands on the capture edge
    wr(4'h4, 32'h3, 4'b0001);
    repeat (L) @(negedge wb_clk_i);
    wr(4'h8, 32'h2, 4'b0001);
    repeat (2) @(negedge wb_clk_i);
    rd(4'h8, d); chk("t6_done_wins", d, 32'h2);
    wr(4'h8, 32'h2, 4'b0001);

    // 3a: start while busy
    wr(4'h0, 32'h0000_0908, 4'b0011);
    e0 = en_cyc;
    wr(4'h4, 32'h1, 4'b0001);
    wr(4'h4, 32'h1, 4'b0001);
    repeat (8) @(negedge wb_clk_i);
    chk("t3_one_capture", 32'(en_cyc - e0), 32'(L + 1));
    rd(4'h8, d); chk("t3_overrun", d, 32'h6);
    rd(4'hC, d); chk("t3_result", d, 32'd72);
    wr(4'h8, 32'h6, 4'b0001);
    // 3b: operand write while busy
    wr(4'h0, 32'h0000_0705, 4'b0011);
    wr(4'h4, 32'h1, 4'b0001);
    wr(4'h0, 32'h0000_1111, 4'b0011);
    repeat (6) @(negedge wb_clk_i);
    rd(4'h0, d); chk("t3_opnd_kept", d, 32'h0705);
    rd(4'h8, d); chk("t3_ovr_opnd", d, 32'h6);
    rd(4'hC, d); chk("t3_result2", d, 32'd35);
    wr(4'h8, 32'h6, 4'b0001);

    // 4: address misses and byte enables
    wb_xfer(BASE + 32'h10, 1'b1, 32'h0000_AAAA, 4'hF, d, a);
    chk("t4_miss_ack", 32'(a), 32'd0);
    wb_xfer(32'h4000_0000, 1'b1, 32'h0000_5555, 4'hF, d, a);
    chk("t4_out_ack", 32'(a), 32'd0);
    rd(4'h0, d); chk("t4_opnd_same", d, 32'h0705);
    wr(4'h0, 32'h0000_AB00, 4'b0010);
    rd(4'h0, d); chk("t4_sel_b", d, 32'hAB05);

    // 5: async reset mid-run
    wr(4'h0, 32'h0000_0302, 4'b0011);
    wr(4'h4, 32'h3, 4'b0001);
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1;
    #1 chk("t5_rst_outs", {31'h0, wbs_ack_o, wbs_dat_o, mul_a, mul_b, mul_enable, irq}, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    rd(4'h4, d); chk("t5_ctrl_rst", d, 32'h0);
    rd(4'hC, d); chk("t5_result_rst", d, 32'h0);
    wr(4'h0, 32'h0000_0302, 4'b0011);
    wr(4'h4, 32'h1, 4'b0001);
    repeat (6) @(negedge wb_clk_i);
    rd(4'hC, d); chk("t5_result", d, 32'h6);
    rd(4'h8, d); chk("t5_status", d, 32'h2);

    repeat (2) @(negedge wb_clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
